// File: rtl/spike_pkg.sv
// Shared types and width helpers for the spike window sequencer and its
// per-channel magnitude comparators.
package spike_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_SETTLE = 3'd3,
    ST_OUTPUT = 3'd4
  } state_e;

  // Bits needed for a counter that holds 0..n-1, never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spike_mag_cmp.sv
// One channel: turns a ripple down-count into a magnitude and compares it
// against the latched threshold. Purely combinational; the top registers it.
module spike_mag_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] cnt_value,
  input  logic [W-1:0] threshold,
  output logic [W-1:0] mag,
  output logic         fire
);

  // The counter starts at zero and counts down, so its negation is the count.
  assign mag  = W'(0) - cnt_value;
  assign fire = (mag >= threshold);

endmodule

// File: rtl/spike_window_ctrl.sv
// Window sequencer for a bank of ripple down-counters: clear, stream WIN_LEN
// bit columns, wait for ripple settling, then hand off one result word.
module spike_window_ctrl #(
  parameter int size_code = 8,
  parameter int NUM_CH    = 4,
  parameter int WIN_LEN   = 16,
  parameter int SETTLE    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [NUM_CH-1:0]           bit_in,
  output logic                        in_ready,
  output logic                        cnt_enable,
  output logic [NUM_CH-1:0]           cnt_bitin,
  output logic                        cnt_clear,
  input  logic [NUM_CH*size_code-1:0] cnt_value,
  input  logic [size_code-1:0]        threshold,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH-1:0]           out_fire,
  output logic [NUM_CH*size_code-1:0] out_count,
  output logic                        busy
);

  import spike_pkg::*;

  localparam int BW = cnt_width(WIN_LEN + 1);
  localparam int SW = cnt_width(SETTLE);
  localparam logic [BW-1:0] LAST_COL    = BW'(WIN_LEN - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  if (WIN_LEN < 1 || WIN_LEN >= (1 << size_code)) begin : g_bad_win_len
    $error("WIN_LEN must satisfy 1 <= WIN_LEN < 2**size_code");
  end
  if (SETTLE < size_code) begin : g_bad_settle
    $error("SETTLE must be at least size_code");
  end

  state_e                        state_q, state_d;
  logic [BW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]                 settle_cnt_q, settle_cnt_d;
  logic [size_code-1:0]          thr_q, thr_d;
  logic                          out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]             fire_q, fire_d;
  logic [NUM_CH*size_code-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]             fire_w;
  logic [NUM_CH*size_code-1:0]   mag_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spike_mag_cmp #(.W(size_code)) u_cmp (
      .cnt_value (cnt_value[i*size_code +: size_code]),
      .threshold (thr_q),
      .mag       (mag_w[i*size_code +: size_code]),
      .fire      (fire_w[i])
    );
  end

  assign in_ready   = (state_q == ST_STREAM);
  assign cnt_enable = in_valid & in_ready;
  assign cnt_bitin  = bit_in & {NUM_CH{cnt_enable}};
  assign cnt_clear  = reset | (state_q == ST_CLEAR);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_fire   = fire_q;
  assign out_count  = count_q;

  always_comb begin
    // NOTE: every signal assigned below gets its hold value first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    settle_cnt_d = settle_cnt_q;
    thr_d        = thr_q;
    out_valid_d  = out_valid_q;
    fire_d       = fire_q;
    count_d      = count_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        thr_d        = threshold;
        bit_cnt_d    = '0;
        settle_cnt_d = '0;
        state_d      = ST_STREAM;
      end
      ST_STREAM: if (cnt_enable) begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == LAST_COL) state_d = ST_SETTLE;
      end
      // Counters are only trustworthy once the ripple has settled.
      ST_SETTLE: if (settle_cnt_q == SETTLE_LAST) begin
        state_d     = ST_OUTPUT;
        out_valid_d = 1'b1;
        count_d     = mag_w;
        fire_d      = fire_w;
      end else begin
        settle_cnt_d = settle_cnt_q + SW'(1);
      end
      ST_OUTPUT: if (out_ready) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      thr_q        <= '0;
      out_valid_q  <= 1'b0;
      fire_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      thr_q        <= thr_d;
      out_valid_q  <= out_valid_d;
      fire_q       <= fire_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_spike_window_ctrl.sv
// Bench for spike_window_ctrl: emulated counter bank, a timeline model of the
// window, a per-cycle compare process and directed literal expectations.
module tb_spike_window_ctrl;

  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int WL  = 16;
  localparam int ST  = 8;
  localparam int WL2 = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, out_ready;
  logic [3:0]  bit_in;
  logic [7:0]  threshold;
  logic        in_ready, cnt_enable, cnt_clear, out_valid, busy;
  logic [3:0]  cnt_bitin, out_fire;
  logic [31:0] cnt_value, out_count;

  logic        start_l, in_valid_l, out_ready_l;
  logic [3:0]  bit_in_l;
  logic [7:0]  threshold_l;
  logic        in_ready_l, cnt_enable_l, cnt_clear_l, out_valid_l, busy_l;
  logic [3:0]  cnt_bitin_l, out_fire_l;
  logic [31:0] cnt_value_l, out_count_l;

  spike_window_ctrl #(.size_code(W), .NUM_CH(NCH), .WIN_LEN(WL), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .bit_in(bit_in),
    .in_ready(in_ready), .cnt_enable(cnt_enable), .cnt_bitin(cnt_bitin),
    .cnt_clear(cnt_clear), .cnt_value(cnt_value), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_fire(out_fire),
    .out_count(out_count), .busy(busy)
  );

  spike_window_ctrl #(.size_code(W), .NUM_CH(NCH), .WIN_LEN(WL2), .SETTLE(ST)) dut_long (
    .clk(clk), .reset(reset), .start(start_l), .in_valid(in_valid_l), .bit_in(bit_in_l),
    .in_ready(in_ready_l), .cnt_enable(cnt_enable_l), .cnt_bitin(cnt_bitin_l),
    .cnt_clear(cnt_clear_l), .cnt_value(cnt_value_l), .threshold(threshold_l),
    .out_valid(out_valid_l), .out_ready(out_ready_l), .out_fire(out_fire_l),
    .out_count(out_count_l), .busy(busy_l)
  );

  // Emulated counter banks: cleared by cnt_clear, count down on enabled spikes.
  logic [7:0] ctr   [NCH];
  logic [7:0] ctr_l [NCH];
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (cnt_clear) ctr[i] <= 8'd0;
      else if (cnt_enable && cnt_bitin[i]) ctr[i] <= ctr[i] - 8'd1;
      if (cnt_clear_l) ctr_l[i] <= 8'd0;
      else if (cnt_enable_l && cnt_bitin_l[i]) ctr_l[i] <= ctr_l[i] - 8'd1;
    end
  end
  assign cnt_value   = {ctr[3], ctr[2], ctr[1], ctr[0]};
  assign cnt_value_l = {ctr_l[3], ctr_l[2], ctr_l[1], ctr_l[0]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a window is a start stamp, a count of columns taken,
  // the stamp of the last column and the spike totals per channel.
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_t0 = 0, m_cols = 0, m_tlast = 0, m_thr = 0;
  int         m_spk [NCH];
  int         m_res [NCH] = '{0, 0, 0, 0};
  logic [3:0] m_fire = 4'd0;

  function automatic bit exp_busy();
    return !reset && m_active;
  endfunction
  function automatic bit exp_in_ready();
    return !reset && m_active && cyc >= m_t0 + 2 && m_cols < WL;
  endfunction
  function automatic bit exp_valid();
    return !reset && m_active && m_cols == WL && cyc >= m_tlast + 1 + ST;
  endfunction
  function automatic bit exp_clear();
    return reset || (m_active && cyc == m_t0 + 1);
  endfunction
  function automatic logic [31:0] exp_count();
    logic [31:0] v = '0;
    if (!reset) for (int i = 0; i < NCH; i++) v[i*8 +: 8] = 8'(m_res[i]);
    return v;
  endfunction

  always @(posedge clk) begin
    bit rdy, vld;
    rdy = exp_in_ready();
    vld = exp_valid();
    if (reset) begin
      m_active = 1'b0;
      for (int i = 0; i < NCH; i++) m_res[i] = 0;
      m_fire = 4'd0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t0     = cyc;
        m_cols   = 0;
        for (int i = 0; i < NCH; i++) m_spk[i] = 0;
      end
    end else begin
      if (cyc == m_t0 + 1) m_thr = int'(threshold);
      if (m_cols == WL && cyc == m_tlast + ST) begin
        for (int i = 0; i < NCH; i++) begin
          m_res[i]  = m_spk[i] % 256;
          m_fire[i] = (m_res[i] >= m_thr);
        end
      end
      if (rdy && in_valid) begin
        m_cols++;
        for (int i = 0; i < NCH; i++) m_spk[i] += int'(bit_in[i]);
        if (m_cols == WL) m_tlast = cyc;
      end
      if (vld && out_ready) m_active = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    check("busy",       32'(busy),       32'(exp_busy()));
    check("in_ready",   32'(in_ready),   32'(exp_in_ready()));
    check("cnt_clear",  32'(cnt_clear),  32'(exp_clear()));
    check("cnt_enable", 32'(cnt_enable), 32'(in_valid && exp_in_ready()));
    check("cnt_bitin",  32'(cnt_bitin),  32'((in_valid && exp_in_ready()) ? bit_in : 4'd0));
    check("out_valid",  32'(out_valid),  32'(exp_valid()));
    check("out_count",  out_count,       exp_count());
    check("out_fire",   32'(out_fire),   32'(reset ? 4'd0 : m_fire));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  // Column c carries a spike on channel i when c < n_i; optional single-cycle
  // gaps in front of columns 3, 8 and 12 with garbage on bit_in.
  task automatic feed(input int n0, input int n1, input int n2, input int n3,
                      input int ncols, input bit stall);
    int idx = 0;
    int guard = 0;
    logic [15:0] stall_done = '0;
    bit rdy;
    while (idx < ncols && guard < 400) begin
      if (stall && (idx == 3 || idx == 8 || idx == 12) && !stall_done[idx]) begin
        stall_done[idx] = 1'b1;
        in_valid = 1'b0;
        bit_in   = 4'hF;
      end else begin
        in_valid = 1'b1;
        bit_in   = {idx < n3, idx < n2, idx < n1, idx < n0};
      end
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (in_valid && rdy) idx++;
      guard++;
    end
    check("feed_done", 32'(idx), 32'(ncols));
    in_valid = 1'b0;
    bit_in   = 4'd0;
  endtask

  task automatic wait_valid(input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic accept();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bit_in = 4'd0; threshold = 8'd0;
    start_l = 1'b0; in_valid_l = 1'b0; out_ready_l = 1'b0;
    bit_in_l = 4'd0; threshold_l = 8'd0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cnt_clear", 32'(cnt_clear), 32'd1);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_count", out_count,      32'd0);
    check("rst_out_fire",  32'(out_fire),  32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Basic window.
    threshold = 8'd5;
    pulse_start(t0);
    feed(7, 5, 0, 16, WL, 1'b0);
    wait_valid(t0, lat);
    check("basic_latency", 32'(lat), 32'd26);
    check("basic_count",   out_count, {8'd16, 8'd0, 8'd5, 8'd7});
    check("basic_fire",    32'(out_fire), 32'b1011);
    accept();

    // Same stimulus with three input gaps.
    tick();
    pulse_start(t0);
    feed(7, 5, 0, 16, WL, 1'b1);
    wait_valid(t0, lat);
    check("stall_latency", 32'(lat), 32'd29);
    check("stall_count",   out_count, {8'd16, 8'd0, 8'd5, 8'd7});
    check("stall_fire",    32'(out_fire), 32'b1011);
    accept();

    // Backpressure with an ignored start, then a back-to-back window.
    tick();
    threshold = 8'd3;
    pulse_start(t0);
    feed(1, 2, 3, 4, WL, 1'b0);
    wait_valid(t0, lat);
    check("bp_latency", 32'(lat), 32'd26);
    for (int k = 0; k < 10; k++) begin
      tick();
      start = (k == 4);
    end
    start = 1'b0;
    @(negedge clk);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    check("bp_count",      out_count, {8'd4, 8'd3, 8'd2, 8'd1});
    check("bp_fire",       32'(out_fire), 32'b1100);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("b2b_clear", 32'(cnt_clear), 32'd1);
    feed(4, 4, 4, 4, WL, 1'b0);
    wait_valid(t0, lat);
    check("b2b_latency", 32'(lat), 32'd26);
    check("b2b_count",   out_count, {8'd4, 8'd4, 8'd4, 8'd4});
    check("b2b_fire",    32'(out_fire), 32'b1111);
    accept();

    // Reset after six columns, then a fresh window.
    tick();
    threshold = 8'd2;
    pulse_start(t0);
    feed(16, 16, 16, 16, 6, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt_clear", 32'(cnt_clear), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    pulse_start(t0);
    feed(2, 0, 1, 0, WL, 1'b0);
    wait_valid(t0, lat);
    check("post_rst_latency", 32'(lat), 32'd26);
    check("post_rst_count",   out_count, {8'd0, 8'd1, 8'd0, 8'd2});
    check("post_rst_fire",    32'(out_fire), 32'b0001);
    accept();

    // Zero threshold, no spikes.
    tick();
    threshold = 8'd0;
    pulse_start(t0);
    feed(0, 0, 0, 0, WL, 1'b0);
    wait_valid(t0, lat);
    check("zero_count", out_count, 32'd0);
    check("zero_fire",  32'(out_fire), 32'b1111);
    accept();

    // Longest legal window with all-ones input.
    tick();
    threshold_l = 8'd200;
    bit_in_l    = 4'hF;
    start_l     = 1'b1;
    t0 = cyc;
    tick();
    start_l    = 1'b0;
    in_valid_l = 1'b1;
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (out_valid_l) begin
        lat = cyc - t0;
        break;
      end
    end
    check("long_latency", 32'(lat), 32'd265);
    check("long_count",   out_count_l, {8'd255, 8'd255, 8'd255, 8'd255});
    check("long_fire",    32'(out_fire_l), 32'b1111);
    in_valid_l = 1'b0;
    tick();
    out_ready_l = 1'b1;
    tick();
    out_ready_l = 1'b0;
    tick();
    @(negedge clk);
    check("long_idle", 32'(busy_l), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
